pair_stream_reader: RTL and testbench

Read-side counterpart to the draw block's paired address counter. It walks the same even/odd address pairs over a dual-port memory, starting at pair 3328 and ending at pair 3456 by default. It drives one read per pair on both ports, captures the two words, and streams them out one word per beat over a valid/ready interface: even word first, then odd. It sits between the dual-port frame memory and the downstream draw/display consumer.

---
 rtl/draw_pkg.sv | 17 +
 rtl/pair_addr_gen.sv | 38 +++
 rtl/pair_stream_reader.sv | 122 ++++++++++++
 tb/tb_pair_stream_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared draw-path definitions: reader FSM states and the
// default pair window used by both the write counter and reader.
package draw_pkg;

  localparam int START_PAIR_DEF = 3328;
  localparam int END_PAIR_DEF   = 3456;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT_A,
    S_EMIT_B,
    S_DONE
  } rd_state_t;

endpackage

// File: rtl/pair_addr_gen.sv
// Pair index register for the reader; produces the even/odd
// address pair and flags the final pair of the window.
module pair_addr_gen
  import draw_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int START_PAIR = START_PAIR_DEF,
  parameter int END_PAIR   = END_PAIR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic              active,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              last
);

  localparam int PW = ADDR_W - 1;

  logic [PW-1:0] pair;

  always_ff @(posedge clk) begin
    if (reset) begin
      pair <= PW'(START_PAIR);
    end else if (load) begin
      pair <= PW'(START_PAIR);
    end else if (inc) begin
      pair <= pair + PW'(1);
    end
  end

  assign last   = (pair == PW'(END_PAIR));
  assign addr_a = active ? {pair, 1'b0} : '0;
  assign addr_b = active ? {pair, 1'b1} : '0;

endmodule

// File: rtl/pair_stream_reader.sv
// Reads even/odd word pairs from a dual-port memory and streams
// them out one word per beat, even word first.
module pair_stream_reader
  import draw_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int START_PAIR = START_PAIR_DEF,
  parameter int END_PAIR   = END_PAIR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  if (START_PAIR > END_PAIR ||
      END_PAIR >= (1 << (ADDR_W - 1))) begin : g_bad_window
    $error("pair_stream_reader: illegal pair window");
  end

  rd_state_t         state;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              last;
  logic              load;
  logic              inc;

  assign load = (state == S_IDLE) && start;
  assign inc  = (state == S_EMIT_B) && out_ready && !last;

  pair_addr_gen #(
    .ADDR_W     (ADDR_W),
    .START_PAIR (START_PAIR),
    .END_PAIR   (END_PAIR)
  ) u_addr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .inc    (inc),
    .active (busy),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .last   (last)
  );

  // Output word comes straight from the capture registers,
  // so it cannot move while a beat is stalled.
  assign out_data = (state == S_EMIT_A) ? a_q :
                    (state == S_EMIT_B) ? b_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          a_q       <= rd_data_a;
          b_q       <= rd_data_b;
          out_valid <= 1'b1;
          state     <= S_EMIT_A;
        end
        S_EMIT_A: begin
          if (out_ready) begin
            out_last <= last;
            state    <= S_EMIT_B;
          end
        end
        S_EMIT_B: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rd_en <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_stream_reader.sv
// Random-stimulus bench for pair_stream_reader against a
// queue-based model of the expected word stream.
module tb_pair_stream_reader;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam int SP = 3328;
  localparam int EP = 3456;
  localparam int NP = EP - SP + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          out_ready;
  logic          busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] rda, rdb, out_data;

  logic          start1;
  logic          busy1, done1, rd_en1, out_valid1, out_last1;
  logic [AW-1:0] addr_a1, addr_b1;
  logic [DW-1:0] rda1, rdb1, out_data1;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  pair_stream_reader #(
    .DATA_W(DW), .ADDR_W(AW), .START_PAIR(SP), .END_PAIR(EP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .done(done), .rd_en(rd_en), .addr_a(addr_a),
    .addr_b(addr_b), .rd_data_a(rda), .rd_data_b(rdb),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  pair_stream_reader #(
    .DATA_W(DW), .ADDR_W(AW), .START_PAIR(7), .END_PAIR(7)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1),
    .done(done1), .rd_en(rd_en1), .addr_a(addr_a1),
    .addr_b(addr_b1), .rd_data_a(rda1), .rd_data_b(rdb1),
    .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_last(out_last1)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rda <= mem[addr_a];
      rdb <= mem[addr_b];
    end
    if (rd_en1) begin
      rda1 <= mem[addr_a1];
      rdb1 <= mem[addr_b1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: always ready, 1: fixed 5/3-cycle stall, 2: random
  task automatic run_pass(input int mode, input int rst_beat,
                          input bit extra_start);
    logic [DW-1:0] q[$];
    int            exp_pair, beats, rds, t0, stall, hs_last;
    bit            fin, first_v, r, pv;
    logic [DW-1:0] pd;
    logic          pl;
    for (int p = SP; p <= EP; p++) begin
      q.push_back(mem[2*p]);
      q.push_back(mem[2*p+1]);
    end
    exp_pair = SP; beats = 0; rds = 0; stall = 0;
    hs_last = -10; fin = 0; first_v = 0; pv = 0;
    pd = '0; pl = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      if (k > 0) step();
      if (rd_en) begin
        if (rds == 0) chk("rd_lat", cyc - t0, 1);
        chk("addr_a", addr_a, 2*exp_pair);
        chk("addr_b", addr_b, 2*exp_pair + 1);
        exp_pair++;
        rds++;
      end
      if (pv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      chk("done", done, cyc == hs_last + 1);
      if (cyc == hs_last + 2) begin
        chk("busy_end", busy, 0);
        fin = 1;
      end
      r = 1'b1;
      if (mode == 1 && out_valid &&
          (beats == 6 || beats == 7) &&
          stall < ((beats == 6) ? 5 : 3)) begin
        r = 1'b0;
        stall++;
      end else if (mode == 2) begin
        r = ($urandom_range(0, 3) != 0);
      end
      out_ready = r;
      start = extra_start && (beats == 5 || beats == 100);
      pv = 0;
      if (out_valid) begin
        if (!first_v) begin
          first_v = 1;
          chk("valid_lat", cyc - t0, 3);
        end
        if (r) begin
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            chk("beat_data", out_data, q[0]);
            chk("beat_last", out_last, q.size() == 1);
            void'(q.pop_front());
            if (q.size() == 0) hs_last = cyc;
          end
          beats++;
          stall = 0;
        end else begin
          pv = 1;
          pd = out_data;
          pl = out_last;
        end
      end
      if (rst_beat > 0 && beats == rst_beat) begin
        step();
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_data", out_data, 0);
        for (int j = 0; j < 8; j++) begin
          chk("rst_no_done", done, 0);
          step();
        end
        chk("rst_idle", busy, 0);
        return;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!fin) chk("timeout", 0, 1);
    chk("beats", beats, 2*NP);
    chk("reads", rds, NP);
    chk("q_left", q.size(), 0);
  endtask

  task automatic run_short();
    int nb, nd, nr;
    nb = 0; nd = 0; nr = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      if (rd_en1) begin
        chk("s_addr_a", addr_a1, 14);
        chk("s_addr_b", addr_b1, 15);
        nr++;
      end
      if (done1) begin
        chk("s_done_after", nb, 2);
        nd++;
      end
      if (out_valid1) begin
        nb++;
        chk("s_data", out_data1, mem[13 + nb]);
        chk("s_last", out_last1, nb == 2);
      end
    end
    chk("s_beats", nb, 2);
    chk("s_dones", nd, 1);
    chk("s_reads", nr, 1);
    chk("s_busy", busy1, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_rd_en", rd_en, 0);
    chk("r_addr_a", addr_a, 0);
    chk("r_addr_b", addr_b, 0);
    chk("r_data", out_data, 0);
    chk("r_valid", out_valid, 0);
    chk("r_last", out_last, 0);
    while (cyc < 10) step();
    run_pass(0, 0, 0);
    run_pass(1, 0, 0);
    run_pass(0, 40, 0);
    run_pass(2, 0, 1);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_rd_en", rd_en, 0);
    step();
    chk("rs_busy2", busy, 0);
    chk("rs_rd_en2", rd_en, 0);
    run_short();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
